// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one imem read per registered pc, buffers
// returned words in a 2-entry queue for decode, and computes the PC register input.
module fetch_stage #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned QDEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_target,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [DW-1:0] id_instr,
    output logic [AW-1:0] id_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    count;
    logic          rd_ptr, wr_ptr;
    logic [DW-1:0] instr_q [QDEPTH];
    logic [AW-1:0] pc_q    [QDEPTH];
    logic          push, pop;

    assign imem_addr = {pc[AW-1:2], 2'b00};
    assign id_valid  = (count != 2'd0);
    assign id_instr  = instr_q[rd_ptr];
    assign id_pc     = pc_q[rd_ptr];
    // A redirect flushes the queue, so a same-cycle handshake is not honoured.
    assign pop       = id_valid && id_ready && !redirect_valid;

    always_comb begin
        state_nxt = state;
        pc_next   = pc;
        push      = 1'b0;
        imem_req  = (state == FETCH) && (count < 2'(QDEPTH)) && !redirect_valid && !reset;
        if (reset) begin
            state_nxt = FETCH;
        end else if (redirect_valid) begin
            pc_next = redirect_target;
            case (state)
                WAIT, DRAIN: state_nxt = imem_rvalid ? FETCH : DRAIN;
                default:     state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: if (imem_req) state_nxt = WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        push      = 1'b1;
                        pc_next   = pc + AW'(4);
                        state_nxt = FETCH;
                    end
                end
                DRAIN:   if (imem_rvalid) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a PC register, a variable-latency memory and a
// transaction-level model of the fetch queue drive directed and random steps.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_stage #(.AW(32), .DW(32), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: queue of delivered {instr, pc}, one outstanding flag,
    // and whether the outstanding response has been cancelled by a redirect.
    logic [63:0] m_q[$];
    bit          m_out = 1'b0;
    bit          m_discard = 1'b0;
    logic [31:0] pc_reg = 32'h0;

    // Memory: one pending read with a countdown to its response.
    bit          mem_pend = 1'b0;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    bit          spur_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed timeout expected condition reached", tag);
    endtask

    task automatic step(input bit rst, input bit redir, input logic [31:0] tgt,
                        input bit rdy, input int unsigned lat);
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_next;
        logic [63:0] head;
        pc              = pc_reg;
        reset           = rst;
        redirect_valid  = redir;
        redirect_target = tgt;
        id_ready        = rdy;
        imem_rvalid     = 1'b0;
        imem_rdata      = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_pend    = 1'b0;
            end
        end else if (spur_en && !m_out && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
        end
        #1;
        e_req   = !m_out && (m_q.size() < 2) && !redir && !rst;
        e_addr  = pc & 32'hFFFF_FFFC;
        e_valid = (m_q.size() != 0);
        if (rst)                                    e_next = pc;
        else if (redir)                             e_next = tgt;
        else if (m_out && !m_discard && imem_rvalid) e_next = pc + 32'd4;
        else                                        e_next = pc;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, e_addr);
        chk("pc_next", pc_next, e_next);
        chk("id_valid", 32'(id_valid), 32'(e_valid));
        if (e_valid) begin
            head = m_q[0];
            chk("id_instr", id_instr, head[63:32]);
            chk("id_pc", id_pc, head[31:0]);
        end
        if (rst) begin
            m_q.delete();
            m_out = 1'b0;
            m_discard = 1'b0;
        end else if (redir) begin
            m_q.delete();
            if (m_out && !imem_rvalid) m_discard = 1'b1;
            else begin
                m_out = 1'b0;
                m_discard = 1'b0;
            end
        end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (m_out && imem_rvalid) begin
                if (!m_discard) m_q.push_back({imem_rdata, pc});
                m_out = 1'b0;
                m_discard = 1'b0;
            end
            if (e_req) begin
                m_out    = 1'b1;
                mem_pend = 1'b1;
                mem_cnt  = lat;
                mem_addr = e_addr;
            end
        end
        pc_reg = rst ? 32'h0 : e_next;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        pc = 32'h0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        id_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);

        // reset, then steady fetch with latency 1
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        repeat (8) step(0, 0, 0, 1, 1);

        // back-pressure fills the queue, then drain in order
        repeat (8) step(0, 0, 0, 0, 1);
        repeat (8) step(0, 0, 0, 1, 1);

        // redirect while waiting on a latency-3 read
        for (int i = 0; i < 20 && !(m_out && mem_pend && mem_cnt == 3); i++) step(0, 0, 0, 1, 3);
        if (!(m_out && mem_pend)) timeout("reach_wait");
        step(0, 1, 32'h100, 1, 3);
        repeat (10) step(0, 0, 0, 1, 1);

        // redirect coincident with a response and a decode handshake
        for (int i = 0; i < 20 && !(m_out && m_q.size() == 1 && mem_pend && mem_cnt == 1); i++)
            step(0, 0, 0, 0, 1);
        if (!(m_out && m_q.size() == 1)) timeout("reach_coincident");
        step(0, 1, 32'h200, 1, 1);
        repeat (6) step(0, 0, 0, 1, 1);

        // address wrap
        step(0, 1, 32'hFFFF_FFFC, 1, 1);
        repeat (6) step(0, 0, 0, 1, 1);

        // reset while waiting, response arrives a cycle later
        for (int i = 0; i < 20 && !(m_out && mem_pend && mem_cnt == 2); i++) step(0, 0, 0, 1, 2);
        if (!(m_out && mem_pend)) timeout("reach_reset_wait");
        step(1, 0, 0, 1, 2);
        step(0, 0, 0, 0, 2);
        repeat (6) step(0, 0, 0, 1, 2);

        // random traffic
        spur_en = 1'b1;
        repeat (600) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
